// File: rtl/fetch_unit_pkg.sv
// Shared widths, FSM state encoding and branch-offset helper for the fetch unit.
package fetch_unit_pkg;

    localparam int unsigned PC_W    = 10;
    localparam int unsigned INSTR_W = 16;
    localparam int unsigned BOFF_W  = 6;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StHold = 2'd2
    } fetch_state_e;

    function automatic logic [PC_W-1:0] sext_boff(input logic [BOFF_W-1:0] off);
        return {{(PC_W - BOFF_W){off[BOFF_W-1]}}, off};
    endfunction

endpackage

// File: rtl/fetch_unit_pc_next.sv
// Next-PC arithmetic: redirect target mux (jump over branch), relative branch add, increment.
module fetch_unit_pc_next
    import fetch_unit_pkg::*;
(
    input  logic              jmp_en,
    input  logic [PC_W-1:0]   jmp_dir,
    input  logic              branch_en,
    input  logic [BOFF_W-1:0] branch_dir,
    input  logic [PC_W-1:0]   pc,
    input  logic [PC_W-1:0]   fetch_pc,
    output logic              redirect,
    output logic [PC_W-1:0]   target,
    output logic [PC_W-1:0]   fetch_inc
);

    logic [PC_W-1:0] branch_target;

    // All additions wrap modulo 2**PC_W.
    always_comb begin
        branch_target = pc + sext_boff(branch_dir);
        fetch_inc     = fetch_pc + PC_W'(1);
        redirect      = jmp_en | branch_en;
        target        = jmp_en ? jmp_dir : branch_target;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: IDLE/REQ/HOLD sequencer with jump/branch redirect and in-flight discard.
// Optional FETCH_LINK_EN adds linkPc, loaded with pc+1 on every accepted jump.
module fetch_unit
    import fetch_unit_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    output logic               memReq,
    output logic [PC_W-1:0]    memAddr,
    input  logic               memAck,
    input  logic [INSTR_W-1:0] memData,
    input  logic               jmpEnable,
    input  logic [PC_W-1:0]    jmpDir,
    input  logic               branchEnable,
    input  logic [BOFF_W-1:0]  branchDir,
    input  logic               stall,
    output logic [INSTR_W-1:0] instr,
    output logic               instrValid,
    output logic [PC_W-1:0]    pc
`ifdef FETCH_LINK_EN
    ,
    output logic [PC_W-1:0]    linkPc
`endif
);

    fetch_state_e       state_q, state_d;
    logic [PC_W-1:0]    fetch_pc_q, fetch_pc_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [PC_W-1:0]    mem_addr_q, mem_addr_d;
    logic               discard_q, discard_d;

    logic               redirect;
    logic [PC_W-1:0]    target;
    logic [PC_W-1:0]    fetch_inc;

    fetch_unit_pc_next u_pc_next (
        .jmp_en     (jmpEnable),
        .jmp_dir    (jmpDir),
        .branch_en  (branchEnable),
        .branch_dir (branchDir),
        .pc         (pc_q),
        .fetch_pc   (fetch_pc_q),
        .redirect   (redirect),
        .target     (target),
        .fetch_inc  (fetch_inc)
    );

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        mem_addr_d = mem_addr_q;
        discard_d  = discard_q;

        unique case (state_q)
            StIdle: begin
                state_d = StReq;
                if (redirect) fetch_pc_d = target;
            end
            StReq: begin
                if (memAck) begin
                    if (discard_q || redirect) begin
                        // Returning word belongs to a flushed path: drop it and refetch.
                        discard_d  = 1'b0;
                        fetch_pc_d = redirect ? target : fetch_pc_q;
                    end else begin
                        instr_d    = memData;
                        pc_d       = fetch_pc_q;
                        fetch_pc_d = fetch_inc;
                        state_d    = StHold;
                    end
                end else if (redirect) begin
                    // Let the outstanding read finish on its original address.
                    fetch_pc_d = target;
                    discard_d  = 1'b1;
                end
            end
            StHold: begin
                if (redirect) begin
                    fetch_pc_d = target;
                    state_d    = StReq;
                end else if (!stall) begin
                    state_d = StReq;
                end
            end
            default: state_d = StIdle;
        endcase

        // Latch a new address only when a fresh request begins.
        if (state_d == StReq && (state_q != StReq || memAck)) mem_addr_d = fetch_pc_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            fetch_pc_q <= '0;
            pc_q       <= '0;
            instr_q    <= '0;
            mem_addr_q <= '0;
            discard_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            mem_addr_q <= mem_addr_d;
            discard_q  <= discard_d;
        end
    end

`ifdef FETCH_LINK_EN
    logic [PC_W-1:0] link_pc_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            link_pc_q <= '0;
        end else if (jmpEnable) begin
            link_pc_q <= pc_q + PC_W'(1);
        end
    end

    assign linkPc = link_pc_q;
`endif

    assign memReq     = (state_q == StReq);
    assign memAddr    = mem_addr_q;
    assign instrValid = (state_q == StHold);
    assign instr      = instr_q;
    assign pc         = pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: memory responder plus transaction-level model, separate monitor.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        memReq;
    logic [9:0]  memAddr;
    logic        memAck = 1'b0;
    logic [15:0] memData = 16'h0;
    logic        jmpEnable;
    logic [9:0]  jmpDir;
    logic        branchEnable;
    logic [5:0]  branchDir;
    logic        stall;
    logic [15:0] instr;
    logic        instrValid;
    logic [9:0]  pc;
`ifdef FETCH_LINK_EN
    logic [9:0]  linkPc;
`endif

    fetch_unit dut (
        .clk          (clk),
        .reset        (reset),
        .memReq       (memReq),
        .memAddr      (memAddr),
        .memAck       (memAck),
        .memData      (memData),
        .jmpEnable    (jmpEnable),
        .jmpDir       (jmpDir),
        .branchEnable (branchEnable),
        .branchDir    (branchDir),
        .stall        (stall),
        .instr        (instr),
        .instrValid   (instrValid),
        .pc           (pc)
`ifdef FETCH_LINK_EN
        ,
        .linkPc       (linkPc)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [9:0]  pc;
        logic [15:0] instr;
    } exp_t;
    exp_t expq[$];

    logic [15:0] mem [1024];

    // Reference model state (architectural view, not the RTL's encoding)
    logic [9:0] exp_next = 10'd0;
    logic [9:0] last_pc = 10'd0;
    logic [9:0] req_addr = 10'd0;
    logic [9:0] link_exp = 10'd0;
    logic       flushed = 1'b0;
    logic       req_active = 1'b0;
    logic       req_pre = 1'b0;
    int         lat = 0;
    int         lat_mode = 1;
    logic       e_rst = 1'b1;
    logic       e_stall = 1'b0;
    logic       e_redir = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: event not seen within 50 cycles, required it (t=%0t)", name, $time);
    endtask

    function automatic logic [9:0] branch_target(input logic [9:0] base, input logic [5:0] off);
        int o;
        o = (off > 6'd31) ? int'(off) - 64 : int'(off);
        return 10'((int'(base) + o + 1024) % 1024);
    endfunction

    // Model + memory: runs just after each rising edge, sees the inputs that edge sampled.
    always begin
        logic [9:0] tgt;
        exp_t       e;
        @(posedge clk);
        #2;
        e_rst   = reset;
        e_stall = stall;
        e_redir = jmpEnable | branchEnable;
        if (reset) begin
            exp_next   = 10'd0;
            last_pc    = 10'd0;
            flushed    = 1'b0;
            req_active = 1'b0;
            link_exp   = 10'd0;
        end else begin
            tgt = jmpEnable ? jmpDir : branch_target(last_pc, branchDir);
            if (jmpEnable) link_exp = last_pc + 10'd1;
            if (req_pre && memAck) begin
                if (!flushed && !e_redir) begin
                    e.pc     = req_addr;
                    e.instr  = mem[req_addr];
                    expq.push_back(e);
                    last_pc  = req_addr;
                    exp_next = req_addr + 10'd1;
                end
                flushed    = 1'b0;
                req_active = 1'b0;
            end else if (req_pre && e_redir) begin
                flushed = 1'b1;
            end
            if (e_redir) exp_next = tgt;
        end

        if (req_active) begin
            check("req_held", memReq, 1);
            if (!memReq) req_active = 1'b0;
        end
        if (memReq) begin
            if (!req_active) begin
                check("req_addr", memAddr, exp_next);
                req_addr   = exp_next;
                req_active = 1'b1;
                lat        = (lat_mode < 0) ? int'($urandom_range(3, 0)) : lat_mode;
            end else begin
                check("addr_stable", memAddr, req_addr);
            end
        end
        req_pre = memReq;

        memAck  = 1'b0;
        memData = 16'($urandom);
        if (e_rst) begin
            memAck = 1'b1;  // stray ack in the first cycle after reset
        end else if (req_active && memReq) begin
            if (lat == 0) begin
                memAck  = 1'b1;
                memData = mem[memAddr];
            end else begin
                lat--;
            end
        end
    end

    // Monitor: pops the scoreboard whenever a new instruction is presented.
    logic        valid_prev = 1'b0;
    logic [9:0]  held_pc = 10'd0;
    logic [15:0] held_instr = 16'h0;

    always begin
        exp_t e;
        logic exp_hold;
        @(negedge clk);
        if (e_rst) begin
            check("rst_valid", instrValid, 0);
            check("rst_memreq", memReq, 0);
            check("rst_pc", pc, 0);
            check("rst_instr", instr, 0);
            check("rst_memaddr", memAddr, 0);
        end else if (valid_prev) begin
            exp_hold = e_stall && !e_redir;
            check("hold_valid", instrValid, exp_hold);
            check("hold_memreq", memReq, !exp_hold);
            if (exp_hold) begin
                check("hold_pc", pc, held_pc);
                check("hold_instr", instr, held_instr);
            end
        end
        if (instrValid && !valid_prev) begin
            if (expq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_instr: got pc=%0h instr=%0h, required none (t=%0t)",
                         pc, instr, $time);
            end else begin
                e = expq.pop_front();
                check("pc", pc, e.pc);
                check("instr", instr, e.instr);
            end
        end
`ifdef FETCH_LINK_EN
        check("link", linkPc, link_exp);
`endif
        valid_prev = instrValid;
        held_pc    = pc;
        held_instr = instr;
    end

    task automatic wait_valid(input string name);
        int n = 0;
        while (instrValid && n < 50) begin @(negedge clk); n++; end
        while (!instrValid && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) fail_timeout(name);
    endtask

    task automatic wait_req(input string name);
        int n = 0;
        while (!memReq && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) fail_timeout(name);
    endtask

    task automatic pulse(input logic j, input logic [9:0] jd, input logic b, input logic [5:0] bd);
        #1;
        jmpEnable    = j;
        jmpDir       = jd;
        branchEnable = b;
        branchDir    = bd;
        @(negedge clk);
        #1;
        jmpEnable    = 1'b0;
        branchEnable = 1'b0;
    endtask

    initial begin
        foreach (mem[i]) mem[i] = 16'($urandom);
        mem[0]       = 16'h0280;
        reset        = 1'b1;
        stall        = 1'b0;
        jmpEnable    = 1'b0;
        jmpDir       = 10'd0;
        branchEnable = 1'b0;
        branchDir    = 6'd0;
        lat_mode     = 1;
        repeat (3) @(negedge clk);
        #1 reset = 1'b0;

        wait_valid("first_fetch");
        check("first_pc", pc, 0);
        check("first_instr", instr, 16'h0280);
        repeat (12) @(negedge clk);

        wait_valid("stall_fetch");
        #1 stall = 1'b1;
        repeat (3) @(negedge clk);
        #1 stall = 1'b0;

        @(negedge clk);
        pulse(1'b1, 10'd5, 1'b0, 6'd0);
        wait_valid("jmp5");
        check("jmp5_pc", pc, 5);
        pulse(1'b0, 10'd0, 1'b1, 6'b111110);
        wait_valid("br_neg");
        check("br_neg_pc", pc, 3);

        @(negedge clk);
        pulse(1'b1, 10'd1022, 1'b0, 6'd0);
        wait_valid("jmp1022");
        check("jmp1022_pc", pc, 1022);
        pulse(1'b0, 10'd0, 1'b1, 6'd3);
        wait_valid("br_wrap");
        check("br_wrap_pc", pc, 1);

        lat_mode = 3;
        wait_valid("pre_flush");
        wait_req("flush_req");
        pulse(1'b1, 10'h200, 1'b1, 6'd5);
        wait_valid("flush_target");
        check("flush_pc", pc, 10'h200);

        lat_mode = 0;
        @(negedge clk);
        pulse(1'b1, 10'd1022, 1'b0, 6'd0);
        wait_valid("seq1022");
        check("seq1022_pc", pc, 1022);
        wait_valid("seq1023");
        check("seq1023_pc", pc, 1023);
        wait_valid("seq_wrap");
        check("seq_wrap_pc", pc, 0);

        lat_mode = 3;
        wait_valid("pre_reset");
        wait_req("reset_req");
        #1 reset = 1'b1;
        @(negedge clk);
        #1 reset = 1'b0;
        wait_valid("after_reset");
        check("after_reset_pc", pc, 0);
        check("after_reset_instr", instr, 16'h0280);

        lat_mode = 1;
        @(negedge clk);
        pulse(1'b1, 10'h3FF, 1'b0, 6'd0);
        wait_valid("jmp3ff");
        check("jmp3ff_pc", pc, 10'h3FF);
        pulse(1'b1, 10'h010, 1'b0, 6'd0);
`ifdef FETCH_LINK_EN
        check("link_wrap", linkPc, 0);
`endif

        lat_mode = -1;
        repeat (3000) begin
            @(negedge clk);
            #1;
            reset        = ($urandom_range(199, 0) == 0);
            jmpEnable    = ($urandom_range(15, 0) == 0);
            jmpDir       = 10'($urandom);
            branchEnable = ($urandom_range(11, 0) == 0);
            branchDir    = 6'($urandom);
            stall        = ($urandom_range(2, 0) == 0);
        end
        @(negedge clk);
        #1;
        reset        = 1'b0;
        jmpEnable    = 1'b0;
        branchEnable = 1'b0;
        stall        = 1'b0;
        repeat (30) @(negedge clk);
        check("queue_empty", expq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 clk  input  1  single system clock; all state updates on rising edge.
REQ-002 reset  input  1  synchronous, active-high reset.
REQ-003 memReq  output  1  instruction-memory read request.
REQ-004 memAddr  output  10  word address of the request; stable while memReq=1.
REQ-005 memAck  input  1  memory completion; memData valid in the same cycle.
REQ-006 memData  input  16  instruction word returned by memory.
REQ-007 jmpEnable  input  1  absolute jump request from decodec.
REQ-008 jmpDir  input  10  absolute jump target.
REQ-009 branchEnable  input  1  taken-branch request from decodec.
REQ-010 branchDir  input  6  signed two's-complement offset, relative to pc output.
REQ-011 stall  input  1  downstream not ready; holds the presented instruction.
REQ-012 instr  output  16  instruction presented to decodec input "in".
REQ-013 instrValid  output  1  instr holds a valid, non-flushed instruction.
REQ-014 pc  output  10  address of the instruction on instr.

Function
REQ-015 FSM states SHALL be IDLE, REQ, HOLD.
- IDLE: one cycle after reset, then go to REQ.
- REQ: memReq=1, memAddr=fetchPc; leave on memAck.
- HOLD: instrValid=1; leave when stall=0.
REQ-016 On memAck in REQ with no pending discard, instr<=memData, pc<=fetchPc, fetchPc<=fetchPc+1, go to HOLD.
REQ-017 In HOLD with stall=0 and no redirect, the block SHALL return to REQ next cycle; the back-to-back issue rate is one instruction per two cycles plus memory latency.
REQ-018 A redirect is jmpEnable=1 or branchEnable=1 in any cycle. jmpEnable has priority over branchEnable.
REQ-019 Jump target = jmpDir. Branch target = pc + sign-extend(branchDir), modulo 1024.
REQ-020 On redirect: fetchPc<=target and instrValid<=0 next cycle.
- In HOLD, go to REQ regardless of stall.
- In REQ without memAck, set discard. The in-flight request SHALL complete unchanged. Its memAck data SHALL be dropped, discard cleared, and a new REQ issued to the target.
- In REQ with memAck in the same cycle, drop the returning data and go to REQ at the target.
REQ-021 fetchPc increment SHALL wrap 1023->0 with no error indication.
REQ-022 A redirect while instrValid=0 SHALL still update fetchPc; the branch base is the last pc value.
REQ-023 memAddr SHALL NOT change while memReq=1 and memAck=0.

Reset
REQ-024 On reset: state=IDLE, fetchPc=0, pc=0, instr=16'h0000, instrValid=0, memReq=0, memAddr=0, discard=0.
REQ-025 Reset mid-request SHALL abandon the request; a memAck in the first cycle after reset SHALL be ignored.
REQ-026 Reset SHALL override redirect and stall inputs in the same cycle.

Configuration
REQ-027 Macro FETCH_LINK_EN.
- Defined: adds output linkPc[9:0]. On an accepted jmpEnable it loads pc+1 (wrapping); reset value 0.
- Undefined: port and register absent; all other behaviour identical.

Structure
REQ-028 The shared include def.v SHALL hold the FSM state encodings, PC_W=10, INSTR_W=16 and BOFF_W=6.
REQ-029 A combinational sub-module pc_next SHALL compute the target mux, the sign-extended branch add and the increment.

Verification
REQ-030 Reset then memAck after 1 wait cycle, memData=16'h0280, stall=0 -> memAddr 0,1,2… in successive requests; instr=16'h0280, pc=0, instrValid=1 for one HOLD cycle.
REQ-031 stall=1 for 3 cycles in HOLD -> instr and pc unchanged, memReq=0 throughout; REQ resumes the cycle after stall falls.
REQ-032 Branch checks:
- pc=5 with branchEnable, branchDir=6'b111110 -> next memAddr=3.
- pc=1022 with branchDir=6'd3 -> memAddr=1.
REQ-033 jmpEnable, jmpDir=10'h200 and branchEnable together -> next memAddr=10'h200; pending memAck data discarded and instrValid stays 0 until the new fetch returns.
REQ-034 Sequential fetch from 1023 -> following memAddr=0.
REQ-035 Reset asserted mid-REQ with memAck the next cycle -> instrValid stays 0 and the fetch restarts at address 0.
REQ-036 With FETCH_LINK_EN defined, jump accepted at pc=10'h3FF -> linkPc=0.
